// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road (NS/EW) intersection controller with
// pedestrian-shortened greens and a night flashing-yellow mode.
module traffic_light_ctrl #(
    parameter int GREEN_CYC  = 20,
    parameter int MIN_GREEN  = 5,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int FLASH_CYC  = 8,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic       ns_green,
    output logic       ns_yellow,
    output logic       ns_red,
    output logic       ew_green,
    output logic       ew_yellow,
    output logic       ew_red,
    output logic       ped_walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        AR_TO_NS  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        AR_TO_EW  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FLASH     = 3'd6
    } state_t;

    // Last count value of each timed phase (counter starts at 0 on entry)
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ped_pend;
    logic             flash_on;
    logic             in_green;
    logic             yellow_first;

    assign in_green     = (state == NS_GREEN) || (state == EW_GREEN);
    assign yellow_first = ((state == NS_YELLOW) || (state == EW_YELLOW)) && (cnt == '0);
    assign phase        = state;

    // State and phase counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= AR_TO_NS;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; the counter restarts on every state change and on each FLASH half-period
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        case (state)
            AR_TO_NS: begin
                if (cnt == ALLRED_LAST)
                    state_nxt = night_mode ? FLASH : NS_GREEN;
            end
            NS_GREEN: begin
                if ((cnt == GREEN_LAST) || (ped_pend && (cnt >= MIN_LAST)))
                    state_nxt = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (cnt == YELLOW_LAST)
                    state_nxt = AR_TO_EW;
            end
            AR_TO_EW: begin
                if (cnt == ALLRED_LAST)
                    state_nxt = night_mode ? FLASH : EW_GREEN;
            end
            EW_GREEN: begin
                if ((cnt == GREEN_LAST) || (ped_pend && (cnt >= MIN_LAST)))
                    state_nxt = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (cnt == YELLOW_LAST)
                    state_nxt = AR_TO_NS;
            end
            FLASH: begin
                if (cnt == FLASH_LAST) begin
                    cnt_nxt = '0;
                    if (!night_mode)
                        state_nxt = AR_TO_NS;
                end
            end
            default: begin
                state_nxt = AR_TO_NS;
            end
        endcase
        if (state_nxt != state)
            cnt_nxt = '0;
    end

    // Sticky pedestrian request: consumed on the first yellow cycle, but a new request that cycle wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ped_pend <= 1'b0;
        else
            ped_pend <= ped_req || (ped_pend && !yellow_first);
    end

    // Walk indication latches once a request is seen during green and drops when the green is over
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ped_walk <= 1'b0;
        else
            ped_walk <= in_green && (ped_req || ped_pend || ped_walk);
    end

    // Night blink phase: starts lit on FLASH entry and toggles at each half-period end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flash_on <= 1'b1;
        else if (state != FLASH)
            flash_on <= 1'b1;
        else if (cnt == FLASH_LAST)
            flash_on <= !flash_on;
    end

    // Moore lamp decode from the state register
    always_comb begin
        ns_green  = 1'b0;
        ns_yellow = 1'b0;
        ns_red    = 1'b0;
        ew_green  = 1'b0;
        ew_yellow = 1'b0;
        ew_red    = 1'b0;
        case (state)
            NS_GREEN: begin
                ns_green = 1'b1;
                ew_red   = 1'b1;
            end
            NS_YELLOW: begin
                ns_yellow = 1'b1;
                ew_red    = 1'b1;
            end
            EW_GREEN: begin
                ns_red   = 1'b1;
                ew_green = 1'b1;
            end
            EW_YELLOW: begin
                ns_red    = 1'b1;
                ew_yellow = 1'b1;
            end
            FLASH: begin
                ns_yellow = flash_on;
                ew_yellow = flash_on;
            end
            default: begin
                ns_red = 1'b1;
                ew_red = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Testbench for traffic_light_ctrl: directed phase-timing scenarios followed by
// randomized ped_req/night_mode traffic, all compared against a behavioural model.
module tb_traffic_light_ctrl;

    localparam int GREEN  = 8;
    localparam int MING   = 3;
    localparam int YELLOW = 2;
    localparam int ALLRED = 1;
    localparam int FLASHC = 4;

    logic       clk;
    logic       rst;
    logic       ped_req;
    logic       night_mode;
    logic       ns_green, ns_yellow, ns_red;
    logic       ew_green, ew_yellow, ew_red;
    logic       ped_walk;
    logic [2:0] phase;
    logic [5:0] lamps;

    int n_checks;
    int n_pass;
    int walk_seen;
    int nsy_seen;
    int period_acc;
    bit night_lvl;

    // Behavioural model: phase id, cycles spent in it, pending request, walk lamp
    int m_phase;
    int m_age;
    bit m_pend;
    bit m_walk;

    traffic_light_ctrl #(
        .GREEN_CYC (GREEN),
        .MIN_GREEN (MING),
        .YELLOW_CYC(YELLOW),
        .ALLRED_CYC(ALLRED),
        .FLASH_CYC (FLASHC),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ped_req   (ped_req),
        .night_mode(night_mode),
        .ns_green  (ns_green),
        .ns_yellow (ns_yellow),
        .ns_red    (ns_red),
        .ew_green  (ew_green),
        .ew_yellow (ew_yellow),
        .ew_red    (ew_red),
        .ped_walk  (ped_walk),
        .phase     (phase)
    );

    assign lamps = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        else
            n_pass++;
    endtask

    function automatic void modelReset();
        m_phase = 0;
        m_age   = 0;
        m_pend  = 1'b0;
        m_walk  = 1'b0;
    endfunction

    // Expected lamps {nsG,nsY,nsR,ewG,ewY,ewR}; night blink is lit in even half-periods since FLASH entry
    function automatic logic [5:0] modelLamps();
        logic b;
        b = ((m_age / FLASHC) % 2) == 0;
        case (m_phase)
            1:       return 6'b100001;
            2:       return 6'b010001;
            4:       return 6'b001100;
            5:       return 6'b001010;
            6:       return {1'b0, b, 1'b0, 1'b0, b, 1'b0};
            default: return 6'b001001;
        endcase
    endfunction

    // Advance the model by one clock edge given the inputs held before that edge
    function automatic void stepModel(input bit p, input bit n);
        bit leave;
        int nxt;
        bit is_green;
        leave    = 1'b0;
        nxt      = m_phase;
        is_green = (m_phase == 1) || (m_phase == 4);
        case (m_phase)
            0: begin leave = (m_age + 1 >= ALLRED); nxt = n ? 6 : 1; end
            3: begin leave = (m_age + 1 >= ALLRED); nxt = n ? 6 : 4; end
            1, 4: begin
                leave = (m_age + 1 >= GREEN) || (m_pend && (m_age + 1 >= MING));
                nxt   = m_phase + 1;
            end
            2: begin leave = (m_age + 1 >= YELLOW); nxt = 3; end
            5: begin leave = (m_age + 1 >= YELLOW); nxt = 0; end
            6: begin leave = (((m_age + 1) % FLASHC) == 0) && !n; nxt = 0; end
            default: begin leave = 1'b1; nxt = 0; end
        endcase
        m_walk = is_green && (m_pend || p || m_walk);
        if (p)
            m_pend = 1'b1;
        else if (((m_phase == 2) || (m_phase == 5)) && (m_age == 0))
            m_pend = 1'b0;
        if (leave) begin
            m_phase = nxt;
            m_age   = 0;
        end else begin
            m_age++;
        end
    endfunction

    task automatic applyStimulus(input bit p, input bit n);
        ped_req    = p;
        night_mode = n;
        @(posedge clk);
        stepModel(p, n);
        #1;
        checkOutput("phase", phase, m_phase);
        checkOutput("lamps", lamps, modelLamps());
        checkOutput("walk", ped_walk, m_walk);
        if (phase != 3'd6) begin
            checkOutput("safety", (ns_green | ns_yellow) & (ew_green | ew_yellow), 0);
            checkOutput("ns_onehot", $countones({ns_green, ns_yellow, ns_red}), 1);
            checkOutput("ew_onehot", $countones({ew_green, ew_yellow, ew_red}), 1);
        end
        if (ped_walk)  walk_seen++;
        if (ns_yellow) nsy_seen++;
    endtask

    // Run until the observed phase changes; len counts the cycles it was seen, starting with the current one
    task automatic runPhase(input bit p, input bit n, output int len);
        logic [2:0] start_phase;
        start_phase = phase;
        len = 1;
        for (int k = 0; k < 200; k++) begin
            applyStimulus(p, n);
            if (phase != start_phase) return;
            len++;
        end
        checkOutput("phase_timeout", 1, 0);
    endtask

    task automatic checkPhaseLen(input string tag, input int exp_phase, input int exp_len);
        int len;
        checkOutput({tag, "_id"}, phase, exp_phase);
        runPhase(1'b0, night_lvl, len);
        checkOutput({tag, "_len"}, len, exp_len);
        period_acc += len;
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        bit p;
        n_checks   = 0;
        n_pass     = 0;
        walk_seen  = 0;
        nsy_seen   = 0;
        period_acc = 0;
        night_lvl  = 1'b0;
        rst        = 1'b1;
        ped_req    = 1'b0;
        night_mode = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_phase", phase, 0);
        checkOutput("rst_lamps", lamps, 6'b001001);
        checkOutput("rst_walk", ped_walk, 0);
        rst = 1'b0;

        // Baseline sequence, no requests
        checkPhaseLen("base_ar_ns", 0, ALLRED);
        period_acc = 0;
        checkPhaseLen("base_ns_g", 1, GREEN);
        checkPhaseLen("base_ns_y", 2, YELLOW);
        checkPhaseLen("base_ar_ew", 3, ALLRED);
        checkPhaseLen("base_ew_g", 4, GREEN);
        checkPhaseLen("base_ew_y", 5, YELLOW);
        checkPhaseLen("base_ar_ns2", 0, ALLRED);
        checkOutput("base_period", period_acc, 22);

        // One-cycle request at NS_GREEN cnt=1 shortens green to MIN_GREEN
        applyStimulus(1'b0, 1'b0);
        walk_seen = 0;
        applyStimulus(1'b1, 1'b0);
        runPhase(1'b0, 1'b0, len);
        checkOutput("ped_green_len", len + 2, MING);
        checkOutput("ped_to_yellow", phase, 2);
        runPhase(1'b0, 1'b0, len);
        checkOutput("ped_yellow_len", len, YELLOW);
        checkOutput("ped_walk_cycles", walk_seen, 2);

        // Request during EW_YELLOW is held for the next NS green
        checkPhaseLen("hold_ar_ew", 3, ALLRED);
        checkPhaseLen("hold_ew_g", 4, GREEN);
        checkOutput("hold_ew_y_id", phase, 5);
        applyStimulus(1'b1, 1'b0);
        runPhase(1'b0, 1'b0, len);
        checkOutput("hold_ew_y_len", len + 1, YELLOW);
        checkPhaseLen("hold_ar_ns", 0, ALLRED);
        walk_seen = 0;
        checkPhaseLen("hold_ns_g", 1, MING);
        checkOutput("hold_walk_seen", walk_seen != 0, 1);

        // Night mode raised mid NS_GREEN
        checkPhaseLen("n_ns_y", 2, YELLOW);
        checkPhaseLen("n_ar_ew", 3, ALLRED);
        checkPhaseLen("n_ew_g", 4, GREEN);
        checkPhaseLen("n_ew_y", 5, YELLOW);
        checkPhaseLen("n_ar_ns", 0, ALLRED);
        repeat (3) applyStimulus(1'b0, 1'b0);
        night_lvl = 1'b1;
        runPhase(1'b0, 1'b1, len);
        checkOutput("n_green_len", len, GREEN - 3);
        checkPhaseLen("n_ns_y2", 2, YELLOW);
        checkPhaseLen("n_ar_ew2", 3, ALLRED);
        checkOutput("n_flash_entry", phase, 6);
        checkOutput("n_flash_start", ns_yellow, 1);
        nsy_seen = 0;
        repeat (FLASHC - 1) applyStimulus(1'b0, 1'b1);
        checkOutput("n_flash_on_half", nsy_seen, FLASHC - 1);
        repeat (FLASHC) applyStimulus(1'b0, 1'b1);
        checkOutput("n_flash_off_half", nsy_seen, FLASHC - 1);
        night_lvl = 1'b0;
        for (int k = 0; k < 3 * FLASHC; k++) begin
            if (phase != 3'd6) break;
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("n_exit_ar", phase, 0);
        checkPhaseLen("n_exit_ar_len", 0, ALLRED);
        checkOutput("n_exit_green", phase, 1);

        // Asynchronous reset mid EW_GREEN
        for (int k = 0; k < 100; k++) begin
            if (phase == 3'd4) break;
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("r_in_ew_green", phase, 4);
        repeat (2) applyStimulus(1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("r_async_phase", phase, 0);
        checkOutput("r_async_lamps", lamps, 6'b001001);
        checkOutput("r_async_walk", ped_walk, 0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkPhaseLen("r_ar_ns", 0, ALLRED);
        checkPhaseLen("r_ns_g", 1, GREEN);

        // Randomized requests and night mode
        for (int k = 0; k < 10000; k++) begin
            p = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0)
                night_lvl = !night_lvl;
            applyStimulus(p, night_lvl);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-road intersection controller, the next generation of the basic NS/EW traffic light. It sequences green, yellow and all-red phases for the north-south (NS) and east-west (EW) roads, with cycle durations set by parameters. It also shortens the current green when a pedestrian requests the crossing, and supports a night flashing-yellow mode. It sits directly under the lab top level and drives lamp outputs that go straight to board LEDs.

## Interface
- GREEN_CYC, default 20: nominal green duration in clk cycles (≥1)
- MIN_GREEN, default 5: earliest green exit once a pedestrian request is pending (1 ≤ MIN_GREEN ≤ GREEN_CYC)
- YELLOW_CYC, default 4: yellow duration in cycles (≥1)
- ALLRED_CYC, default 2: all-red clearance duration in cycles (≥1)
- FLASH_CYC, default 8: half-period of the night-mode yellow blink in cycles (≥1)
- CNT_W, default 16: phase counter width; every duration parameter must fit in CNT_W bits
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ped_req  input  1  pedestrian crossing request; a pulse of any length is captured
- night_mode  input  1  level input; high requests flashing-yellow operation
- ns_green, ns_yellow, ns_red  output  1 each  NS lamp drives
- ew_green, ew_yellow, ew_red  output  1 each  EW lamp drives
- ped_walk  output  1  high during any green on which a pedestrian request was serviced
- phase  output  3  current state encoding, for debug and verification

## Operation
- States and their 3-bit encodings:
  - AR_TO_NS = 0: all red, next phase NS green
  - NS_GREEN = 1
  - NS_YELLOW = 2
  - AR_TO_EW = 3: all red, next phase EW green
  - EW_GREEN = 4
  - EW_YELLOW = 5
  - FLASH = 6
- A phase counter `cnt` is cleared to 0 on every state entry and increments once per cycle.
- Normal state transitions:
  - AR_TO_NS → NS_GREEN when cnt == ALLRED_CYC-1
  - NS_GREEN → NS_YELLOW when cnt == GREEN_CYC-1, or when ped_pend && cnt ≥ MIN_GREEN-1
  - NS_YELLOW → AR_TO_EW when cnt == YELLOW_CYC-1
  - The EW side follows the same sequence, with AR_TO_NS following EW_YELLOW.
- Night mode:
  - night_mode is sampled only when an all-red state ends. If night_mode is high at that point, the next state is FLASH instead of the green state.
  - In FLASH, ns_yellow and ew_yellow blink together: they toggle each FLASH_CYC cycles and start at 1. All other lamps are 0.
  - FLASH → AR_TO_NS when night_mode is low at the end of a blink half-period (cnt == FLASH_CYC-1).
- Pedestrian requests:
  - ped_pend is a sticky flag, set on any cycle with ped_req high.
  - It clears on the first cycle of any yellow state, unless ped_req is high in that same cycle, in which case set wins.
  - A request that arrives during yellow, all-red or FLASH is held and serviced on the next green.
- ped_walk is registered:
  - It goes high in the cycle after ped_pend is seen high during a green state.
  - It stays high until that green ends.
- Lamp outputs are decoded from the state register only (Moore): exactly one of green/yellow/red is lit per road, except in FLASH.
- Safety invariant: ns_green/ns_yellow and ew_green/ew_yellow are never both active outside FLASH.
- Reset mid-operation: all state is discarded immediately and the controller returns to the reset state.

## Timing
- Reset values:
  - phase = AR_TO_NS, cnt = 0, ped_pend = 0, ped_walk = 0
  - ns_red = ew_red = 1; all green and yellow outputs = 0
- First NS green: phase = NS_GREEN is visible ALLRED_CYC cycles after the first rising clk edge following rst deassertion.
- State durations in cycles:
  - green: GREEN_CYC, or (MIN_GREEN, or entry + 1 if the pending request arrives later) when a request is pending
  - yellow: YELLOW_CYC
  - all-red: ALLRED_CYC
- A full cycle without requests is 2·(GREEN_CYC+YELLOW_CYC+ALLRED_CYC) cycles.
- ped_req latency: ped_pend is set at the first rising edge with ped_req high. A green already at cnt ≥ MIN_GREEN-1 exits on the following edge.
- Simultaneous events:
  - night_mode rising during green has no effect until the following all-red ends.
  - ped_req and a green timeout in the same cycle cause a single transition to yellow; the request is not double-serviced.
- Counter: cnt never wraps in normal use because it is cleared on every transition. CNT_W must hold max(parameter)-1.

## Test plan
- Baseline sequence with GREEN=8, YELLOW=2, ALLRED=1, MIN_GREEN=3, night_mode=0, no requests: phase runs 0,1(8 cycles),2(2),3(1),4(8),5(2),0; period is 22 cycles; lamps match the state decode.
- ped_req 1-cycle pulse at NS_GREEN cnt=1: NS_GREEN lasts exactly 3 cycles; ped_walk is high for 2 cycles; ped_pend is 0 in NS_YELLOW.
- ped_req during EW_YELLOW: request is held; the next NS_GREEN lasts 3 cycles with ped_walk asserted.
- night_mode raised mid NS_GREEN: the normal sequence continues to AR_TO_EW, then FLASH; yellows toggle every FLASH_CYC=4 cycles. Dropping night_mode leads to AR_TO_NS, then NS_GREEN.
- rst pulsed asynchronously mid EW_GREEN, between clock edges: outputs return to both-red immediately; after release the NS_GREEN timing matches the first bullet.
- Random ped_req/night_mode over 10k cycles: safety-invariant assertion never fires, and the green/yellow one-hot property holds per road.
